// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// Booth digit kinds, and the digit-count calculation.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    DIG_Z,
    DIG_P1,
    DIG_P2,
    DIG_M1,
    DIG_M2
  } digit_e;

  // Radix-4 digits per operation; the two guard bits cover unsigned operands.
  function automatic int booth_ndig(input int width);
    return (width + 2) / 2;
  endfunction

  // Overlapping 3-bit multiplier group {b[2i+1], b[2i], b[2i-1]} to digit.
  function automatic digit_e booth_decode(input logic [2:0] grp);
    digit_e d;
    case (grp)
      3'b001, 3'b010: d = DIG_P1;
      3'b011:         d = DIG_P2;
      3'b100:         d = DIG_M2;
      3'b101, 3'b110: d = DIG_M1;
      default:        d = DIG_Z;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_digit_sel.sv
// Combinational Booth multiple select: group + extended multiplicand to the
// signed multiple in {0, +M, +2M, -M, -2M}.
module booth_r4_digit_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       grp,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+2:0] mult
);

  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  assign m1 = {mcand[WIDTH+1], mcand};
  assign m2 = {mcand, 1'b0};

  always_comb begin
    mult = '0;
    case (booth_decode(grp))
      DIG_P1:  mult = m1;
      DIG_P2:  mult = m2;
      DIG_M1:  mult = -m1;
      DIG_M2:  mult = -m2;
      default: mult = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// with valid/ready handshakes on both the operand and product sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | retiring two multiplier bits per cycle, NDIG cycles
// DONE  | product held with out_valid until out_ready
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int NDIG = booth_ndig(WIDTH);
  localparam int CW   = $clog2(NDIG + 1);
  localparam int AW   = 2 * WIDTH + 4;

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_r4_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  state_e           state;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH+2:0] mplier;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;
  logic [AW-1:0]    addend;
  logic [WIDTH+2:0] mult;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] b_ext;

  assign a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{2{is_signed & b[WIDTH-1]}}, b};

  booth_r4_digit_sel #(.WIDTH(WIDTH)) u_sel (
    .grp   (mplier[2:0]),
    .mcand (mcand),
    .mult  (mult)
  );

  // Accumulator arithmetic is modular; the extra headroom keeps the low
  // 2*WIDTH bits exact for both signed and unsigned full-range operands.
  always_comb begin
    addend   = {{(AW-WIDTH-3){mult[WIDTH+2]}}, mult} << {cnt, 1'b0};
    acc_next = acc + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a_ext;
            mplier   <= {b_ext, 1'b0};
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= {{2{mplier[WIDTH+2]}}, mplier[WIDTH+2:2]};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            product   <= acc_next[2*WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Bench for booth_r4_mult: directed vector table and corner sequences at
// WIDTH=8, plus randomized back-to-back traffic at WIDTH=8 and WIDTH=16.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst8, in_valid8, in_ready8, s8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        rst16, in_valid16, in_ready16, s16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  booth_r4_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(s8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  booth_r4_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .is_signed(s16), .out_valid(out_valid16),
    .out_ready(out_ready16), .product(product16), .busy(busy16)
  );

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] xe, ye;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ye = s ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] ref16(input logic s, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] xe, ye;
    xe = s ? {{16{x[15]}}, x} : {16'h0000, x};
    ye = s ? {{16{y[15]}}, y} : {16'h0000, y};
    return xe * ye;
  endfunction

  task automatic idle8();
    int n = 0;
    while (!in_ready8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait8", {31'b0, in_ready8}, 32'd1);
  endtask

  task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] p, output int lat);
    idle8();
    s8 = s; a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      in_valid8 = 1'b0;
      lat++;
    end while (!out_valid8 && lat < 40);
    p = product8;
  endtask

  task automatic rand8(input int nops);
    logic [15:0] q[$];
    int issued = 0, done_ops = 0, cyc = 0;
    logic acc_pend = 1'b0;
    in_valid8 = 1'b0;
    while (done_ops < nops && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (acc_pend) begin in_valid8 = 1'b0; acc_pend = 1'b0; end
      if (!in_valid8 && issued < nops && $urandom_range(0, 3) != 0) begin
        in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      end
      out_ready8 = ($urandom_range(0, 2) != 0);
      if (in_valid8 && in_ready8) begin
        q.push_back(ref8(s8, a8, b8));
        issued++;
        acc_pend = 1'b1;
      end
      if (out_valid8 && out_ready8) begin
        if (q.size() == 0) check("rand8_spurious", 32'd1, 32'd0);
        else check("rand8_product", {16'b0, product8}, {16'b0, q.pop_front()});
        done_ops++;
      end
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    check("rand8_ops", done_ops, nops);
  endtask

  task automatic rand16(input int nops);
    logic [31:0] q[$];
    int issued = 0, done_ops = 0, cyc = 0;
    logic acc_pend = 1'b0;
    in_valid16 = 1'b0;
    while (done_ops < nops && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc_pend) begin in_valid16 = 1'b0; acc_pend = 1'b0; end
      if (!in_valid16 && issued < nops && $urandom_range(0, 3) != 0) begin
        in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
        if ($urandom_range(0, 15) == 0) begin a16 = 16'h8000; b16 = 16'h8000; end
        if ($urandom_range(0, 15) == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
      end
      out_ready16 = ($urandom_range(0, 2) != 0);
      if (in_valid16 && in_ready16) begin
        q.push_back(ref16(s16, a16, b16));
        issued++;
        acc_pend = 1'b1;
      end
      if (out_valid16 && out_ready16) begin
        if (q.size() == 0) check("rand16_spurious", 32'd1, 32'd0);
        else check("rand16_product", product16, q.pop_front());
        done_ops++;
      end
    end
    check("rand16_ops", done_ops, nops);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int lat, n, k;
    int t[2];

    rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
    rst16 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;

    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[4] = '{1'b1, 8'h00, 8'h7F, 16'h0000};
    vecs[5] = '{1'b1, 8'h03, 8'hFB, 16'hFFF1};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[7] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[8] = '{1'b0, 8'h0C, 8'h0D, 16'h009C};
    vecs[9] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};

    repeat (2) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready8}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid8}, 32'd0);
    check("reset_busy", {31'b0, busy8}, 32'd0);
    check("reset_product", {16'b0, product8}, 32'd0);
    rst8 = 1'b0; rst16 = 1'b0;

    fork
      begin
        // Directed table; latency counts edges from presenting in_valid.
        for (int i = 0; i < 10; i++) begin
          run8(vecs[i].s, vecs[i].a, vecs[i].b, p, lat);
          check($sformatf("vec%0d_product", i), {16'b0, p}, {16'b0, vecs[i].p});
          check($sformatf("vec%0d_latency", i), lat, 6);
        end

        // Throughput with in_valid and out_ready held high.
        idle8();
        s8 = 1'b0; a8 = 8'd2; b8 = 8'd3; in_valid8 = 1'b1; out_ready8 = 1'b1;
        n = 0; k = 0; t[0] = 0; t[1] = 0;
        while (k < 2 && n < 40) begin
          if (in_ready8) begin t[k] = n; k++; end
          if (k < 2) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin @(negedge clk); n++; end
        check("throughput_spacing", t[1] - t[0], 7);
        check("throughput_product", {16'b0, product8}, 32'h0006);

        // Back-pressure in DONE.
        idle8();
        s8 = 1'b1; a8 = 8'h05; b8 = 8'h06; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin @(negedge clk); n++; end
        a8 = 8'h11; b8 = 8'h22; in_valid8 = 1'b1;
        for (int c = 0; c < 10; c++) begin
          check("bp_out_valid", {31'b0, out_valid8}, 32'd1);
          check("bp_product", {16'b0, product8}, 32'h001E);
          check("bp_in_ready", {31'b0, in_ready8}, 32'd0);
          @(negedge clk);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", {31'b0, in_ready8}, 32'd1);
        check("bp_release_out_valid", {31'b0, out_valid8}, 32'd0);
        repeat (3) @(negedge clk);
        check("bp_not_queued_busy", {31'b0, busy8}, 32'd0);
        check("bp_product_retained", {16'b0, product8}, 32'h001E);

        // Reset during CALC cycle 3 aborts the operation.
        s8 = 1'b0; a8 = 8'h55; b8 = 8'h33; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
        check("midcalc_busy", {31'b0, busy8}, 32'd1);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("abort_out_valid", {31'b0, out_valid8}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready8}, 32'd1);
        check("abort_product", {16'b0, product8}, 32'd0);
        check("abort_busy", {31'b0, busy8}, 32'd0);
        run8(1'b1, 8'h03, 8'hFB, p, lat);
        check("post_abort_product", {16'b0, p}, 32'h0000FFF1);

        rand8(1200);
      end
      begin
        rand16(1200);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
